lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//  Load/store controller between the RV32I core's MEM stage and the word-organised data memory.
//  - Accepts one byte-addressed load/store per handshake.
//  - Generates word address, byte enables and lane-shifted write data for the memory.
//  - Sign/zero-extends load data and returns one response per request.
//  - Splits word-crossing accesses into two memory cycles, or rejects them (see CONFIGURATION).
// PARAMETERS
//  ADDR_W   5   word-address width of data memory (2**ADDR_W words); byte address = ADDR_W+2 bits
// PORTS
//  clk         in   1       single clock, all state on posedge
//  rst_n       in   1       asynchronous, active-low reset
//  req_valid   in   1       core request valid
//  req_ready   out  1       controller can accept (high only in IDLE)
//  req_we      in   1       1 = store, 0 = load
//  req_funct3  in   3       RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr    in   32      byte address
//  req_wdata   in   32      store data, right-aligned
//  rsp_valid   out  1       one-cycle response strobe; core always accepts
//  rsp_rdata   out  32      extended load data; 0 for stores and errors
//  rsp_err     out  1       access rejected, no memory write performed
//  mem_we      out  1       memory write strobe
//  mem_be      out  4       byte-lane enables, bit i = bits [8i+7:8i]
//  mem_addr    out  ADDR_W  word address
//  mem_wdata   out  32      lane-aligned write data
//  mem_rdata   in   32      combinational read of mem_addr, valid same cycle
// BEHAVIOUR
//  Reset (async): state IDLE. Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//   mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0. Holding registers are cleared.
//  FSM: IDLE -> ACC0 -> [ACC1] -> RESP -> IDLE. RESP -> IDLE is unconditional.
//  IDLE: accepts when req_valid. Latches we, funct3, addr, wdata; off = addr[1:0].
//   Error -> RESP with rsp_err=1 and no memory cycle, when any of:
//   - funct3 is 011/110/111;
//   - a store uses 100/101;
//   - req_addr[31:ADDR_W+2] != 0;
//   - a split access's second word exceeds 2**ADDR_W-1 (no wrap-around);
//   - misalignment is not permitted by config.
//   Otherwise -> ACC0.
//  Shift model: size mask m = 0001/0011/1111. be64 = m << off.
//   wd64 = {32'b0, wdata} << 8*off.
//   crossing = (be64[7:4] != 0), i.e. H with off=3, or W with off != 0.
//  ACC0: mem_addr = addr[ADDR_W+1:2], mem_be = be64[3:0], mem_wdata = wd64[31:0], mem_we = we.
//   Loads capture mem_rdata into lo. -> ACC1 if crossing, else RESP.
//  ACC1: mem_addr = word+1, mem_be = be64[7:4], mem_wdata = wd64[63:32], mem_we = we.
//   Loads capture hi. -> RESP.
//  RESP: rsp_valid=1 for exactly one cycle.
//   Loads: r = {hi, lo} >> 8*off; B/H sign-extend from bit 7/15, BU/HU zero-extend.
//  Outside ACC0/ACC1: mem_we=0, mem_be=0. mem_addr and mem_wdata hold their last value.
//  Latency (accept edge to rsp_valid): 2 cycles normal, 3 split, 1 error.
//   Throughput: one request per 3/4/2 cycles.
//  req_valid while busy: ignored (req_ready=0). Core must hold the request until accepted.
//  Reset during ACC1 of a split store: the ACC0 word stays written. Software-visible, accepted.
// CONFIGURATION
//  LSU_MISALIGN_SPLIT_EN defined:
//   - H with addr[0]=1 and W with addr[1:0] != 0 are legal.
//   - Non-crossing ones (H off=1) take one cycle; crossing ones use ACC1.
//  LSU_MISALIGN_SPLIT_EN undefined:
//   - Any H with addr[0]=1 or W with addr[1:0] != 0 gets an error response.
//   - ACC1 never entered; its logic may be removed.
// STRUCTURE
//  lsu_pkg:
//   - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU;
//   - state enum lsu_state_e {IDLE, ACC0, ACC1, RESP}.
//  Sub-module lsu_align (combinational):
//   - funct3, off, wdata -> be64, wd64;
//   - {hi, lo}, funct3, off -> extended rdata.
//  lsu_ctrl holds only the FSM and holding registers.
// TESTING
//  Bench uses a 32x32 behavioural memory with byte enables, combinational read.
//  1. SW 0xDEADBEEF @0x10, then LW @0x10:
//     mem_be=1111, word 4 written; rsp_rdata=0xDEADBEEF, rsp_err=0, 2-cycle latency.
//  2. SB 0x000000A5 @0x13 -> mem_be=1000, word 4 = 0xA5ADBEEF.
//     LB @0x13 -> 0xFFFFFFA5. LBU @0x13 -> 0x000000A5.
//  3. With _EN: SW 0x11223344 @0x0E -> ACC0 be=1100 word 3; ACC1 be=0011 word 4.
//     LW @0x0E returns 0x11223344, 3-cycle latency.
//     Without _EN: same SW -> rsp_err=1, mem_we never asserted.
//  4. Errors: funct3=011, SB with funct3=100, addr 0x80, LW @0x7E (split past top)
//     -> each rsp_err=1, rsp_rdata=0, memory unchanged.
//  5. Assert rst_n low in ACC1 of a split store -> outputs at reset values immediately,
//     word 3 modified, word 4 untouched, next request served normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: RV32I funct3 codes, FSM states
// and access-geometry helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} lsu_state_e;

    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: size_mask = 4'b0001;
            F3_H, F3_HU: size_mask = 4'b0011;
            default:     size_mask = 4'b1111;
        endcase
    endfunction

    // True when the access spills into the next memory word.
    function automatic logic crosses(input logic [2:0] f3, input logic [1:0] off);
        logic [7:0] be;
        be      = {4'b0000, size_mask(f3)} << off;
        crosses = |be[7:4];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: byte enables and shifted write data for stores,
// realignment and sign/zero extension of load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [63:0] rdata64,
    output logic [7:0]  be64,
    output logic [63:0] wd64,
    output logic [31:0] rdata_ext
);

    logic [4:0]  sh;
    logic [31:0] rs;
    logic [31:0] rs_unused;

    always_comb begin
        sh              = {off, 3'b000};
        be64            = {4'b0000, size_mask(funct3)} << off;
        wd64            = {32'h0, wdata} << sh;
        {rs_unused, rs} = rdata64 >> sh;
        case (funct3)
            F3_B:    rdata_ext = {{24{rs[7]}}, rs[7:0]};
            F3_H:    rdata_ext = {{16{rs[15]}}, rs[15:0]};
            F3_W:    rdata_ext = rs;
            F3_BU:   rdata_ext = {24'h0, rs[7:0]};
            F3_HU:   rdata_ext = {16'h0, rs[15:0]};
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller FSM between the MEM stage and word-organised data memory.
// Define LSU_MISALIGN_SPLIT_EN to allow misaligned H/W accesses (split over two words).
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              we_q, err_q;
    logic [2:0]        f3_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q, lo_q, hi_q;
    logic [ADDR_W-1:0] addr_hold;
    logic [31:0]       wdata_hold;
    logic [ADDR_W-1:0] word;
    logic [7:0]        be64;
    logic [63:0]       wd64;
    logic [31:0]       rdata_ext;
    logic              f3_bad, high_err, misalign_err, top_err, req_err;

    assign word = addr_q[ADDR_W+1:2];

    lsu_align u_align (
        .funct3    (f3_q),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata64   ({hi_q, lo_q}),
        .be64      (be64),
        .wd64      (wd64),
        .rdata_ext (rdata_ext)
    );

    assign f3_bad   = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    assign high_err = |req_addr[31:ADDR_W+2];

`ifdef LSU_MISALIGN_SPLIT_EN
    assign misalign_err = 1'b0;
    assign top_err      = crosses(req_funct3, req_addr[1:0]) && (&req_addr[ADDR_W+1:2]);
`else
    assign misalign_err = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
                       || (req_funct3 == F3_W && req_addr[1:0] != 2'b00);
    assign top_err      = 1'b0;
`endif

    assign req_err = f3_bad || (req_we && req_funct3[2]) || high_err || misalign_err || top_err;

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = addr_hold;
        mem_wdata = wdata_hold;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_err ? RESP : ACC0;
            end
            ACC0: begin
                mem_we    = we_q;
                mem_be    = be64[3:0];
                mem_addr  = word;
                mem_wdata = wd64[31:0];
`ifdef LSU_MISALIGN_SPLIT_EN
                state_d   = crosses(f3_q, addr_q[1:0]) ? ACC1 : RESP;
`else
                state_d   = RESP;
`endif
            end
            ACC1: begin
                mem_we    = we_q;
                mem_be    = be64[7:4];
                mem_addr  = word + 1'b1;
                mem_wdata = wd64[63:32];
                state_d   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (err_q || we_q) ? '0 : rdata_ext;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // mem_addr/mem_wdata keep the last driven value between accesses via the hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr[ADDR_W+1:0];
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        lo_q    <= '0;
                        hi_q    <= '0;
                    end
                end
                ACC0: begin
                    if (!we_q) lo_q <= mem_rdata;
                    addr_hold  <= mem_addr;
                    wdata_hold <= mem_wdata;
                end
                ACC1: begin
                    if (!we_q) hi_q <= mem_rdata;
                    addr_hold  <= mem_addr;
                    wdata_hold <= mem_wdata;
                end
                default: ;
            endcase
        end
    end

endmodule
